otter_hazard_unit: RTL and testbench

//  Parametrised RAW-hazard unit for the OTTER pipeline. It sits between decode and the

---
 rtl/otter_pkg.sv | 31 +++
 rtl/otter_reg_match.sv | 24 ++
 rtl/otter_hazard_unit.sv | 137 +++++++++++++
 tb/tb_otter_hazard_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER opcode map and operand-usage helpers used by the hazard logic.
package otter_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    SYSTEM = 7'b1110011
  } opcode_t;

  localparam logic [4:0] X0 = 5'd0;

  function automatic logic uses_rs1(input logic [31:0] ir);
    return !((ir[6:0] == LUI) || (ir[6:0] == AUIPC) || (ir[6:0] == JAL));
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ir);
    return (ir[6:0] == OP) || (ir[6:0] == BRANCH) || (ir[6:0] == STORE);
  endfunction

  function automatic logic writes_rd(input logic [31:0] ir);
    return !((ir[6:0] == BRANCH) || (ir[6:0] == STORE));
  endfunction

endpackage

// File: rtl/otter_reg_match.sv
// Compares the decode source registers against the destination of one
// downstream stage.
module otter_reg_match
  import otter_pkg::*;
(
  input  logic [31:0] de_ir,
  input  logic        de_valid,
  input  logic [31:0] stage_ir,
  input  logic        stage_valid,
  output logic        hit_rs1,
  output logic        hit_rs2
);

  logic [4:0] w_rd;
  logic       w_live;

  assign w_rd = stage_ir[11:7];

  // Only a real instruction writing a non-x0 register can be a producer.
  assign w_live  = de_valid && stage_valid && writes_rd(stage_ir) && (w_rd != X0);
  assign hit_rs1 = w_live && uses_rs1(de_ir) && (de_ir[19:15] == w_rd);
  assign hit_rs2 = w_live && uses_rs2(de_ir) && (de_ir[24:20] == w_rd);

endmodule

// File: rtl/otter_hazard_unit.sv
// RAW hazard unit: per-stage match, nearest-producer pick, counted interlock
// stall or operand forwarding with load-use stall, plus a stall-cycle counter.
module otter_hazard_unit
  import otter_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int FORWARD_EN = 0,
  parameter int RF_WR_THRU = 1,
  parameter int CNT_W      = 32,
  localparam int FW        = $clog2(DEPTH + 1)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           de_ir,
  input  logic                  de_valid,
  input  logic [DEPTH*32-1:0]   stage_ir,
  input  logic [DEPTH-1:0]      stage_valid,
  input  logic                  flush,
  output logic                  pc_write,
  output logic                  de_en,
  output logic                  ex_clear,
  output logic [FW-1:0]         fwd_a_sel,
  output logic [FW-1:0]         fwd_b_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_STALL  = 1'b1;
  localparam int         NEED_BASE = (RF_WR_THRU != 0) ? DEPTH - 1 : DEPTH;

  logic [DEPTH-1:0] w_hit_rs1;
  logic [DEPTH-1:0] w_hit_rs2;
  logic [DEPTH-1:0] w_is_load;
  logic [FW-1:0]    w_need;
  logic [FW-1:0]    w_fwd_a;
  logic [FW-1:0]    w_fwd_b;
  logic [0:0]       w_state_next;
  logic [FW-1:0]    w_cnt_next;
  logic [0:0]       r_state;
  logic [FW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_stall_cycles;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      otter_reg_match u_match (
        .de_ir       (de_ir),
        .de_valid    (de_valid),
        .stage_ir    (stage_ir[gi*32 +: 32]),
        .stage_valid (stage_valid[gi]),
        .hit_rs1     (w_hit_rs1[gi]),
        .hit_rs2     (w_hit_rs2[gi])
      );
      assign w_is_load[gi] = (stage_ir[gi*32 +: 7] == LOAD);
    end
  endgenerate

  // Descending scan so the nearest (smallest index) producer wins.
  always_comb begin
    w_need = '0;
    if (FORWARD_EN != 0) begin
      if (w_is_load[0] && (w_hit_rs1[0] || w_hit_rs2[0]))
        w_need = FW'(1);
    end else begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if ((w_hit_rs1[k] || w_hit_rs2[k]) && (NEED_BASE - k > 0))
          w_need = FW'(NEED_BASE - k);
      end
    end
  end

  // A load still in EX has no result yet, so it is never a forward source.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_hit_rs1[k] && !(k == 0 && w_is_load[k]))
        w_fwd_a = FW'(k + 1);
      if (w_hit_rs2[k] && !(k == 0 && w_is_load[k]))
        w_fwd_b = FW'(k + 1);
    end
  end

  assign fwd_a_sel = ((FORWARD_EN != 0) && !rst) ? w_fwd_a : '0;
  assign fwd_b_sel = ((FORWARD_EN != 0) && !rst) ? w_fwd_b : '0;

  always_comb begin
    pc_write     = 1'b1;
    de_en        = 1'b1;
    ex_clear     = 1'b0;
    stall        = 1'b0;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (rst) begin
      w_state_next = ST_RUN;
      w_cnt_next   = '0;
    end else if (flush) begin
      ex_clear     = 1'b1;
      w_state_next = ST_RUN;
      w_cnt_next   = '0;
    end else if (r_state == ST_STALL) begin
      pc_write = 1'b0;
      de_en    = 1'b0;
      ex_clear = 1'b1;
      stall    = 1'b1;
      if (r_cnt == FW'(1)) begin
        w_state_next = ST_RUN;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next = r_cnt - FW'(1);
      end
    end else if (w_need != '0) begin
      pc_write     = 1'b0;
      de_en        = 1'b0;
      ex_clear     = 1'b1;
      stall        = 1'b1;
      w_cnt_next   = w_need - FW'(1);
      w_state_next = (w_need > FW'(1)) ? ST_STALL : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (stall && !(&r_stall_cycles))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = rst ? '0 : r_stall_cycles;

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Randomized and directed checks of three hazard-unit configurations against
// a cycle-level reference model of the hazard rules.
module tb_otter_hazard_unit;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [31:0] BUB       = 32'h0000_0013;

  localparam int NI = 3;
  localparam int P_DEPTH [NI] = '{3, 3, 4};
  localparam int P_FWD   [NI] = '{0, 1, 0};
  localparam int P_THRU  [NI] = '{1, 1, 0};
  localparam int P_CW    [NI] = '{32, 4, 8};

  logic         clk = 1'b0;
  logic         rst, flush, de_valid;
  logic [31:0]  de_ir;
  logic [31:0]  s_ir [4];
  logic [3:0]   s_v;
  logic [127:0] s_flat;

  logic        st0, pc0, de0, ex0;
  logic [1:0]  fa0, fb0;
  logic [31:0] sc0;
  logic        st1, pc1, de1, ex1;
  logic [1:0]  fa1, fb1;
  logic [3:0]  sc1;
  logic        st2, pc2, de2, ex2;
  logic [2:0]  fa2, fb2;
  logic [7:0]  sc2;

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_rem    [NI];
  int          m_rem_nx [NI];
  logic [63:0] m_cnt    [NI];
  logic [63:0] m_cnt_nx [NI];

  always #5 clk = ~clk;
  assign s_flat = {s_ir[3], s_ir[2], s_ir[1], s_ir[0]};

  otter_hazard_unit #(.DEPTH(3), .FORWARD_EN(0), .RF_WR_THRU(1), .CNT_W(32)) u_dut_il (
    .clk(clk), .rst(rst), .de_ir(de_ir), .de_valid(de_valid),
    .stage_ir(s_flat[95:0]), .stage_valid(s_v[2:0]), .flush(flush),
    .pc_write(pc0), .de_en(de0), .ex_clear(ex0), .fwd_a_sel(fa0),
    .fwd_b_sel(fb0), .stall(st0), .stall_cycles(sc0));

  otter_hazard_unit #(.DEPTH(3), .FORWARD_EN(1), .RF_WR_THRU(1), .CNT_W(4)) u_dut_fw (
    .clk(clk), .rst(rst), .de_ir(de_ir), .de_valid(de_valid),
    .stage_ir(s_flat[95:0]), .stage_valid(s_v[2:0]), .flush(flush),
    .pc_write(pc1), .de_en(de1), .ex_clear(ex1), .fwd_a_sel(fa1),
    .fwd_b_sel(fb1), .stall(st1), .stall_cycles(sc1));

  otter_hazard_unit #(.DEPTH(4), .FORWARD_EN(0), .RF_WR_THRU(0), .CNT_W(8)) u_dut_deep (
    .clk(clk), .rst(rst), .de_ir(de_ir), .de_valid(de_valid),
    .stage_ir(s_flat), .stage_valid(s_v), .flush(flush),
    .pc_write(pc2), .de_en(de2), .ex_clear(ex2), .fwd_a_sel(fa2),
    .fwd_b_sel(fb2), .stall(st2), .stall_cycles(sc2));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_r1(input logic [31:0] ir);
    return !(ir[6:0] == OPC_LUI || ir[6:0] == OPC_AUIPC || ir[6:0] == OPC_JAL);
  endfunction

  function automatic bit m_r2(input logic [31:0] ir);
    return ir[6:0] == OPC_OP || ir[6:0] == OPC_BRANCH || ir[6:0] == OPC_STORE;
  endfunction

  function automatic bit m_wr(input logic [31:0] ir);
    return !(ir[6:0] == OPC_BRANCH || ir[6:0] == OPC_STORE);
  endfunction

  function automatic bit m_hit(input int i, input bit second);
    logic [31:0] p;
    p = s_ir[i];
    if (!de_valid || !s_v[i] || !m_wr(p) || p[11:7] == 5'd0) return 1'b0;
    if (second) return m_r2(de_ir) && de_ir[24:20] == p[11:7];
    return m_r1(de_ir) && de_ir[19:15] == p[11:7];
  endfunction

  task automatic check_model();
    for (int k = 0; k < NI; k++) begin
      int d, need, fa, fb, first;
      bit e_st, e_pc, e_de, e_ex;
      logic [63:0] smax, e_sc, gfa, gfb, gsc;
      logic gs, gp, gd, gx;
      d = P_DEPTH[k];
      need = 0; fa = 0; fb = 0; first = -1;
      for (int i = d - 1; i >= 0; i--)
        if (m_hit(i, 1'b0) || m_hit(i, 1'b1)) first = i;
      if (P_FWD[k] != 0) begin
        if (first == 0 && s_ir[0][6:0] == OPC_LOAD) need = 1;
        for (int i = d - 1; i >= 0; i--) begin
          if (!(i == 0 && s_ir[0][6:0] == OPC_LOAD)) begin
            if (m_hit(i, 1'b0)) fa = i + 1;
            if (m_hit(i, 1'b1)) fb = i + 1;
          end
        end
      end else if (first >= 0) begin
        need = ((P_THRU[k] != 0) ? d - 1 : d) - first;
        if (need < 0) need = 0;
      end
      e_st = 0; e_pc = 1; e_de = 1; e_ex = 0;
      m_rem_nx[k] = m_rem[k];
      if (rst) begin
        m_rem_nx[k] = 0; fa = 0; fb = 0;
      end else if (flush) begin
        e_ex = 1; m_rem_nx[k] = 0;
      end else if (m_rem[k] > 0) begin
        e_st = 1; m_rem_nx[k] = m_rem[k] - 1;
      end else if (need > 0) begin
        e_st = 1; m_rem_nx[k] = need - 1;
      end
      if (e_st) begin e_pc = 0; e_de = 0; e_ex = 1; end
      smax = (64'd1 << P_CW[k]) - 64'd1;
      e_sc = rst ? 64'd0 : m_cnt[k];
      m_cnt_nx[k] = rst ? 64'd0 : ((e_st && m_cnt[k] < smax) ? m_cnt[k] + 64'd1 : m_cnt[k]);
      case (k)
        0:       begin gs = st0; gp = pc0; gd = de0; gx = ex0; gfa = 64'(fa0); gfb = 64'(fb0); gsc = 64'(sc0); end
        1:       begin gs = st1; gp = pc1; gd = de1; gx = ex1; gfa = 64'(fa1); gfb = 64'(fb1); gsc = 64'(sc1); end
        default: begin gs = st2; gp = pc2; gd = de2; gx = ex2; gfa = 64'(fa2); gfb = 64'(fb2); gsc = 64'(sc2); end
      endcase
      check_eq($sformatf("stall[%0d]", k), 64'(gs), 64'(e_st));
      check_eq($sformatf("pc_write[%0d]", k), 64'(gp), 64'(e_pc));
      check_eq($sformatf("de_en[%0d]", k), 64'(gd), 64'(e_de));
      check_eq($sformatf("ex_clear[%0d]", k), 64'(gx), 64'(e_ex));
      check_eq($sformatf("fwd_a[%0d]", k), gfa, 64'(fa));
      check_eq($sformatf("fwd_b[%0d]", k), gfb, 64'(fb));
      check_eq($sformatf("stall_cycles[%0d]", k), gsc, e_sc);
    end
  endtask

  task automatic cyc(input bit r, input bit f, input bit dv, input logic [31:0] dir,
                     input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                     input logic [31:0] a3, input logic [3:0] v);
    rst = r; flush = f; de_valid = dv; de_ir = dir;
    s_ir[0] = a0; s_ir[1] = a1; s_ir[2] = a2; s_ir[3] = a3; s_v = v;
    #2;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      m_rem[k] = m_rem_nx[k];
      m_cnt[k] = m_cnt_nx[k];
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, BUB, BUB, BUB, BUB, BUB, 4'b0000);
    tick();
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 9))
      0: r[6:0] = OPC_LUI;    1: r[6:0] = OPC_AUIPC;  2: r[6:0] = OPC_JAL;
      3: r[6:0] = OPC_JALR;   4: r[6:0] = OPC_BRANCH; 5: r[6:0] = OPC_LOAD;
      6: r[6:0] = OPC_STORE;  7: r[6:0] = OPC_OPIMM;  8: r[6:0] = OPC_OP;
      default: r[6:0] = OPC_SYSTEM;
    endcase
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  logic [31:0] i_addi5, i_add6, i_add5, i_sub7, i_lw5, i_sw5, i_addi0, i_add1;

  initial begin
    for (int k = 0; k < NI; k++) begin m_rem[k] = 0; m_cnt[k] = 64'd0; end
    i_addi5 = {12'd1, 5'd0, 3'b000, 5'd5, OPC_OPIMM};
    i_add6  = {7'd0, 5'd1, 5'd5, 3'b000, 5'd6, OPC_OP};
    i_add5  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd5, OPC_OP};
    i_sub7  = {7'b0100000, 5'd5, 5'd1, 3'b000, 5'd7, OPC_OP};
    i_lw5   = {12'd0, 5'd2, 3'b010, 5'd5, OPC_LOAD};
    i_sw5   = {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, OPC_STORE};
    i_addi0 = {12'd1, 5'd0, 3'b000, 5'd0, OPC_OPIMM};
    i_add1  = {7'd0, 5'd0, 5'd0, 3'b000, 5'd1, OPC_OP};

    do_reset();
    check_eq("reset_stall_cycles", 64'(sc0), 64'd0);

    // Producer in EX: two stall cycles, then decode advances.
    do_reset();
    cyc(0, 0, 1, i_add6, i_addi5, BUB, BUB, BUB, 4'b0001);
    check_eq("ex_prod_stall_c0", 64'(st0), 64'd1);
    tick();
    cyc(0, 0, 1, i_add6, BUB, i_addi5, BUB, BUB, 4'b0010);
    check_eq("ex_prod_stall_c1", 64'(st0), 64'd1);
    tick();
    cyc(0, 0, 1, i_add6, BUB, BUB, i_addi5, BUB, 4'b0100);
    check_eq("ex_prod_stall_c2", 64'(st0), 64'd0);
    check_eq("ex_prod_de_en_c2", 64'(de0), 64'd1);
    check_eq("ex_prod_count", 64'(sc0), 64'd2);
    tick();
    $display("directed: interlock producer in EX done");

    // Producer in MEM then WB.
    do_reset();
    cyc(0, 0, 1, i_add6, BUB, i_addi5, BUB, BUB, 4'b0010);
    check_eq("mem_prod_stall", 64'(st0), 64'd1);
    tick();
    cyc(0, 0, 1, i_add6, BUB, BUB, i_addi5, BUB, 4'b0100);
    check_eq("wb_prod_stall", 64'(st0), 64'd0);
    check_eq("mem_prod_count", 64'(sc0), 64'd1);
    tick();
    $display("directed: interlock producer in MEM/WB done");

    // Forwarding from EX.
    do_reset();
    cyc(0, 0, 1, i_sub7, i_add5, BUB, BUB, BUB, 4'b0001);
    check_eq("fwd_ex_stall", 64'(st1), 64'd0);
    check_eq("fwd_ex_b", 64'(fb1), 64'd1);
    check_eq("fwd_ex_a", 64'(fa1), 64'd0);
    tick();
    $display("directed: forwarding from EX done");

    // Load-use.
    do_reset();
    cyc(0, 0, 1, i_sw5, i_lw5, BUB, BUB, BUB, 4'b0001);
    check_eq("load_use_stall", 64'(st1), 64'd1);
    tick();
    cyc(0, 0, 1, i_sw5, BUB, i_lw5, BUB, BUB, 4'b0010);
    check_eq("load_use_after_stall", 64'(st1), 64'd0);
    check_eq("load_use_fwd_b", 64'(fb1), 64'd2);
    tick();
    $display("directed: load-use done");

    // x0 and invalid producer.
    do_reset();
    cyc(0, 0, 1, i_add1, i_addi0, BUB, BUB, BUB, 4'b0001);
    check_eq("x0_stall_il", 64'(st0), 64'd0);
    check_eq("x0_stall_fw", 64'(st1), 64'd0);
    tick();
    cyc(0, 0, 1, i_add6, i_addi5, BUB, BUB, BUB, 4'b0000);
    check_eq("invalid_ex_stall", 64'(st0), 64'd0);
    tick();
    $display("directed: x0 and bubble done");

    // Flush in the first cycle of a 2-cycle stall.
    do_reset();
    cyc(0, 0, 1, i_add6, i_addi5, BUB, BUB, BUB, 4'b0001);
    check_eq("flush_pre_stall", 64'(st0), 64'd1);
    tick();
    cyc(0, 1, 1, i_add6, BUB, i_addi5, BUB, BUB, 4'b0010);
    check_eq("flush_stall", 64'(st0), 64'd0);
    check_eq("flush_pc_write", 64'(pc0), 64'd1);
    check_eq("flush_de_en", 64'(de0), 64'd1);
    check_eq("flush_ex_clear", 64'(ex0), 64'd1);
    tick();
    cyc(0, 0, 0, BUB, BUB, BUB, i_addi5, BUB, 4'b0100);
    check_eq("flush_back_to_run", 64'(st0), 64'd0);
    tick();
    $display("directed: flush mid-stall done");

    // Reset in the middle of a stall.
    do_reset();
    cyc(0, 0, 1, i_add6, i_addi5, BUB, BUB, BUB, 4'b0001);
    tick();
    cyc(1, 0, 1, i_add6, i_addi5, BUB, BUB, BUB, 4'b0001);
    check_eq("rst_stall", 64'(st0), 64'd0);
    check_eq("rst_pc_write", 64'(pc0), 64'd1);
    check_eq("rst_de_en", 64'(de0), 64'd1);
    check_eq("rst_ex_clear", 64'(ex0), 64'd0);
    check_eq("rst_count", 64'(sc0), 64'd0);
    check_eq("rst_fwd_a", 64'(fa1), 64'd0);
    check_eq("rst_deep_stall", 64'(st2), 64'd0);
    tick();
    cyc(0, 0, 0, BUB, BUB, BUB, BUB, BUB, 4'b0000);
    check_eq("rst_after_stall", 64'(st0), 64'd0);
    check_eq("rst_after_count", 64'(sc0), 64'd0);
    tick();
    $display("directed: reset mid-stall done");

    for (int c = 0; c < 3000; c++) begin
      logic [3:0] v;
      for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 3) != 0);
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 7) != 0), rand_ir(), rand_ir(), rand_ir(),
          rand_ir(), rand_ir(), v);
      tick();
      if ((c + 1) % 500 == 0)
        $display("random batch ending at cycle %0d: %0d compared, %0d mismatched so far",
                 c + 1, n_cmp, n_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
